div_scheduler: RTL and testbench
================================

DIV_SCHEDULER -- requirements
Module: div_scheduler

Interface
REQ-001 The module SHALL take parameter NREQ, default 4, as the number of requesters sharing one 64-bit divider.
REQ-002 The module SHALL take parameter W, default 64, as the operand width.
REQ-003 The module SHALL take parameter TMO, default 200, as the maximum number of BUSY cycles before abort.
REQ-004 clk_i  in  1  clock; all logic rising-edge.
REQ-005 reset  in  1  reset, synchronous, active-low.
REQ-006 req_valid_i  in  NREQ  per-requester operation request.
REQ-007 req_ready_o  out  NREQ  per-requester accept; one-hot or zero.
REQ-008 req_x_i  in  NREQ*W  dividends; requester k in bits [k*W +: W].
REQ-009 req_y_i  in  NREQ*W  divisors; same packing.
REQ-010 rsp_valid_o  out  1  result available.
REQ-011 rsp_ready_i  in  1  consumer accepts result.
REQ-012 rsp_id_o  out  clog2(NREQ)  index of the requester that owns the result.
REQ-013 rsp_q_o / rsp_r_o  out  W each  quotient / remainder.
REQ-014 rsp_err_o  out  1  divide-by-zero or timeout.
REQ-015 div_start_o  out  1  divider start, level-held for the whole operation.
REQ-016 div_x_o / div_y_o  out  W each  divider operands.
REQ-017 div_rdy_i  in  1  divider done strobe.
REQ-018 div_qr_i  in  2W  divider result {Q, R}.

Function
REQ-019 The FSM SHALL have states IDLE, BUSY and RESP.
REQ-020 In IDLE, round-robin arbitration SHALL assert req_ready_o for exactly one valid requester: the first valid index at or after the priority pointer, wrapping at NREQ.
REQ-021 A transfer SHALL occur on valid&ready; the operands and id SHALL be captured into registers on that edge, and the pointer SHALL become grantee+1 mod NREQ.
REQ-022 req_ready_o SHALL be zero in BUSY and RESP.
REQ-023 If the captured Y is 0, the FSM SHALL go IDLE->RESP without asserting div_start_o, with rsp_err_o=1, Q=all ones and R=X.
REQ-024 Otherwise the FSM SHALL go IDLE->BUSY.
REQ-025 In BUSY, div_start_o SHALL be 1 and div_x_o/div_y_o SHALL be driven from the captured registers, constant for the whole state.
REQ-026 In every other state, div_start_o SHALL be 0 and div_x_o/div_y_o SHALL be 0.
REQ-027 div_rdy_i SHALL be honoured in any BUSY cycle, including the first, because the divider may assert rdy combinationally in the start cycle when X<Y.
REQ-028 On div_rdy_i=1 in BUSY, the block SHALL register Q=div_qr_i[2W-1:W] and R=div_qr_i[W-1:0] with err=0, and the FSM SHALL go to RESP.
REQ-029 A BUSY cycle counter SHALL run from 0; if it reaches TMO-1 without div_rdy_i, the FSM SHALL go to RESP with err=1 and Q=R=0.
REQ-030 If div_rdy_i and timeout coincide, div_rdy_i SHALL win.
REQ-031 div_rdy_i SHALL be ignored outside BUSY.
REQ-032 In RESP, rsp_valid_o SHALL be 1 and the rsp_* outputs SHALL be held stable until rsp_ready_i=1; the FSM SHALL then go to IDLE.
REQ-033 RESP SHALL last at least 1 cycle, so div_start_o is low for at least 2 cycles between operations and the divider returns to idle.
REQ-034 Latency SHALL be: accept edge, then BUSY for the divider cycles, then RESP registered the edge after div_rdy_i; the minimum accept-to-rsp_valid_o latency is 2 cycles.
REQ-035 Requests SHALL be serviced one at a time, with no queueing inside the block.

Reset
REQ-036 While reset=0 at a clock edge, the block SHALL enter IDLE, set the pointer and counter to 0, and clear the captured registers.
REQ-037 While reset=0, all outputs SHALL be 0 from the next cycle.
REQ-038 A reset during BUSY SHALL drop div_start_o at that edge, and the in-flight result SHALL be discarded with no response.

Structure
REQ-039 Package div_sched_pkg SHALL hold the state enum, default W/NREQ/TMO constants and the Y==0 result constants.
REQ-040 Sub-module rr_arbiter SHALL be used: a parameterised NREQ round-robin arbiter with a pointer-update enable.

Verification
REQ-041 Single request k=1, X=100, Y=7 -> rsp_id=1, Q=14, R=2, err=0; div_start_o high until div_rdy_i.
REQ-042 X=5, Y=9 with the divider asserting rdy in the start cycle -> Q=0, R=5, BUSY lasting 1 cycle.
REQ-043 X=123, Y=0 -> div_start_o never asserted; rsp err=1, Q=64'hFFFF_FFFF_FFFF_FFFF, R=123.
REQ-044 All 4 requesters valid continuously -> grant order 0,1,2,3,0; each gets one result; the div_start_o gap is >=2 cycles.
REQ-045 rsp_ready_i held low 10 cycles -> rsp outputs stable throughout, no new grant; rsp_ready_i=1 -> IDLE next cycle.
REQ-046 Stub divider never asserts rdy -> after 200 BUSY cycles, err=1, Q=R=0; then reset=0 mid-BUSY on a new op -> div_start_o=0 next cycle, no response.

Source files
------------

// File: rtl/div_sched_pkg.sv
// rtl/div_sched_pkg.sv - shared state type and constants for the divider scheduler
package div_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } sched_state_e;

    localparam int DEF_NREQ = 4;
    localparam int DEF_W    = 64;
    localparam int DEF_TMO  = 200;

    // Zero divisor result: every quotient bit set, remainder echoes the dividend, error flagged.
    localparam logic DIV0_Q_BIT = 1'b1;
    localparam logic DIV0_ERR   = 1'b1;
    localparam logic TMO_ERR    = 1'b1;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter whose priority pointer advances only when enabled
module rr_arbiter
    import div_sched_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    localparam int IW   = idx_width(NREQ)
) (
    input  logic            clk_i,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            grant_vld
);

    logic [IW-1:0] ptr;
    logic [IW-1:0] cand;

    // First requester at or after the pointer wins, wrapping at NREQ.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IW'((int'(ptr) + i) % NREQ);
            if (!grant_vld && req[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        if (grant_vld) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset) begin
            ptr <= '0;
        end else if (en && grant_vld) begin
            ptr <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);
        end
    end

endmodule

// File: rtl/div_scheduler.sv
// rtl/div_scheduler.sv - shares one divider among NREQ requesters, one operation at a time
module div_scheduler
    import div_sched_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    parameter  int W    = DEF_W,
    parameter  int TMO  = DEF_TMO,
    localparam int IW   = idx_width(NREQ),
    localparam int CW   = idx_width(TMO)
) (
    input  logic              clk_i,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid_i,
    output logic [NREQ-1:0]   req_ready_o,
    input  logic [NREQ*W-1:0] req_x_i,
    input  logic [NREQ*W-1:0] req_y_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [IW-1:0]     rsp_id_o,
    output logic [W-1:0]      rsp_q_o,
    output logic [W-1:0]      rsp_r_o,
    output logic              rsp_err_o,
    output logic              div_start_o,
    output logic [W-1:0]      div_x_o,
    output logic [W-1:0]      div_y_o,
    input  logic              div_rdy_i,
    input  logic [2*W-1:0]    div_qr_i
);

    sched_state_e    state;
    sched_state_e    state_nx;
    logic [NREQ-1:0] grant;
    logic [IW-1:0]   gidx;
    logic            gvld;
    logic            xfer;
    logic            timeout;
    logic [W-1:0]    sel_x;
    logic [W-1:0]    sel_y;
    logic [W-1:0]    x_q;
    logic [W-1:0]    y_q;
    logic [IW-1:0]   id_q;
    logic [W-1:0]    q_q;
    logic [W-1:0]    r_q;
    logic            err_q;
    logic [CW-1:0]   cnt;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk_i     (clk_i),
        .reset     (reset),
        .req       (req_valid_i),
        .en        (xfer),
        .grant     (grant),
        .grant_idx (gidx),
        .grant_vld (gvld)
    );

    assign xfer    = (state == ST_IDLE) && reset && gvld;
    assign sel_x   = req_x_i[int'(gidx)*W +: W];
    assign sel_y   = req_y_i[int'(gidx)*W +: W];
    assign timeout = (cnt == CW'(TMO - 1));

    always_ff @(posedge clk_i) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (xfer) begin
                    state_nx = (sel_y == '0) ? ST_RESP : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (div_rdy_i || timeout) begin
                    state_nx = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Operand capture and result registers; a divider strobe takes precedence over the timeout.
    always_ff @(posedge clk_i) begin
        if (!reset) begin
            x_q   <= '0;
            y_q   <= '0;
            id_q  <= '0;
            q_q   <= '0;
            r_q   <= '0;
            err_q <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (xfer) begin
                        x_q  <= sel_x;
                        y_q  <= sel_y;
                        id_q <= gidx;
                        cnt  <= '0;
                        if (sel_y == '0) begin
                            q_q   <= {W{DIV0_Q_BIT}};
                            r_q   <= sel_x;
                            err_q <= DIV0_ERR;
                        end
                    end
                end
                ST_BUSY: begin
                    cnt <= cnt + CW'(1);
                    if (div_rdy_i) begin
                        q_q   <= div_qr_i[2*W-1:W];
                        r_q   <= div_qr_i[W-1:0];
                        err_q <= 1'b0;
                    end else if (timeout) begin
                        q_q   <= '0;
                        r_q   <= '0;
                        err_q <= TMO_ERR;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready_o = '0;
        div_start_o = 1'b0;
        div_x_o     = '0;
        div_y_o     = '0;
        rsp_valid_o = 1'b0;
        rsp_id_o    = '0;
        rsp_q_o     = '0;
        rsp_r_o     = '0;
        rsp_err_o   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (reset) begin
                    req_ready_o = grant;
                end
            end
            ST_BUSY: begin
                div_start_o = 1'b1;
                div_x_o     = x_q;
                div_y_o     = y_q;
            end
            ST_RESP: begin
                rsp_valid_o = 1'b1;
                rsp_id_o    = id_q;
                rsp_q_o     = q_q;
                rsp_r_o     = r_q;
                rsp_err_o   = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_div_scheduler.sv
// tb/tb_div_scheduler.sv - randomized and directed bench for div_scheduler with an operation-level model
module tb_div_scheduler;

    localparam int NREQ = 4;
    localparam int W    = 64;
    localparam int TMO  = 200;

    logic              clk_i = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid_i;
    logic [NREQ-1:0]   req_ready_o;
    logic [NREQ*W-1:0] req_x_i;
    logic [NREQ*W-1:0] req_y_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [1:0]        rsp_id_o;
    logic [W-1:0]      rsp_q_o;
    logic [W-1:0]      rsp_r_o;
    logic              rsp_err_o;
    logic              div_start_o;
    logic [W-1:0]      div_x_o;
    logic [W-1:0]      div_y_o;
    logic              div_rdy_i;
    logic [2*W-1:0]    div_qr_i;

    div_scheduler #(.NREQ(NREQ), .W(W), .TMO(TMO)) dut (
        .clk_i       (clk_i),
        .reset       (reset),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_x_i     (req_x_i),
        .req_y_i     (req_y_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_id_o    (rsp_id_o),
        .rsp_q_o     (rsp_q_o),
        .rsp_r_o     (rsp_r_o),
        .rsp_err_o   (rsp_err_o),
        .div_start_o (div_start_o),
        .div_x_o     (div_x_o),
        .div_y_o     (div_y_o),
        .div_rdy_i   (div_rdy_i),
        .div_qr_i    (div_qr_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Divider stub: answers after stub_lat start cycles (0 = same cycle), optionally never.
    int stub_cnt = 0;
    int stub_lat = 0;
    int stub_fixed = 0;
    bit stub_rand = 0;
    bit stub_never = 0;
    bit stub_stray = 0;

    always @(posedge clk_i) begin
        if (!div_start_o) begin
            stub_cnt <= 0;
            stub_lat <= stub_rand ? int'($urandom_range(0, 4)) : stub_fixed;
        end else begin
            stub_cnt <= stub_cnt + 1;
        end
    end

    assign div_rdy_i = (div_start_o && !stub_never && stub_cnt == stub_lat) || (stub_stray && !div_start_o);
    assign div_qr_i  = (div_y_o != 0) ? {div_x_o / div_y_o, div_x_o % div_y_o} : '0;

    // Operation-level model: phase 0 waiting, 1 dividing, 2 presenting a result.
    int           m_state = 0;
    int           m_ptr = 0;
    int           m_id = 0;
    int           m_busy = 0;
    logic [W-1:0] m_x = '0;
    logic [W-1:0] m_y = '0;
    logic [W-1:0] m_q = '0;
    logic [W-1:0] m_r = '0;
    logic         m_err = 1'b0;
    bit           prev_rst_low = 0;
    int           rsp_count = 0;
    int           id_rsp[NREQ] = '{default: 0};
    int           grant_log[$];
    bit [NREQ-1:0] hs = '0;
    int           start_run = 0;
    int           last_run = 0;
    int           low_run = 0;
    int           min_gap = 1000;
    int           start_rises = 0;
    bit           have_prev = 0;

    always @(negedge clk_i) begin
        logic [NREQ-1:0] e_ready;
        int g;
        int c;
        e_ready = '0;
        g = -1;
        if (m_state == 0 && reset) begin
            for (int i = 0; i < NREQ; i++) begin
                c = (m_ptr + i) % NREQ;
                if (g < 0 && req_valid_i[c]) g = c;
            end
        end
        if (g >= 0) e_ready[g] = 1'b1;
        if (reset) chk("req_ready", W'(req_ready_o), W'(e_ready));
        else if (prev_rst_low) chk("req_ready_in_reset", W'(req_ready_o), '0);
        chk("div_start", W'(div_start_o), W'(m_state == 1));
        chk("div_x", div_x_o, (m_state == 1) ? m_x : '0);
        chk("div_y", div_y_o, (m_state == 1) ? m_y : '0);
        chk("rsp_valid", W'(rsp_valid_o), W'(m_state == 2));
        if (m_state == 2) begin
            chk("rsp_id", W'(rsp_id_o), W'(m_id));
            chk("rsp_q", rsp_q_o, m_q);
            chk("rsp_r", rsp_r_o, m_r);
            chk("rsp_err", W'(rsp_err_o), W'(m_err));
        end else if (prev_rst_low) begin
            chk("rsp_fields_in_reset", rsp_q_o | rsp_r_o | W'(rsp_id_o) | W'(rsp_err_o), '0);
        end

        hs = req_valid_i & req_ready_o & {NREQ{reset}};
        for (int i = 0; i < NREQ; i++) if (hs[i]) grant_log.push_back(i);
        if (div_start_o) begin
            if (start_run == 0) begin
                start_rises++;
                if (have_prev && low_run < min_gap) min_gap = low_run;
            end
            start_run++;
        end else begin
            if (start_run > 0) begin
                last_run = start_run;
                have_prev = 1;
                low_run = 0;
            end
            start_run = 0;
            low_run++;
        end

        prev_rst_low = !reset;
        if (!reset) begin
            m_state = 0; m_ptr = 0; m_id = 0; m_busy = 0;
            m_x = '0; m_y = '0; m_q = '0; m_r = '0; m_err = 1'b0;
        end else begin
            case (m_state)
                0: if (g >= 0) begin
                    m_x = req_x_i[g*W +: W];
                    m_y = req_y_i[g*W +: W];
                    m_id = g;
                    m_ptr = (g + 1) % NREQ;
                    if (m_y == 0) begin
                        m_state = 2; m_q = '1; m_r = m_x; m_err = 1'b1;
                    end else begin
                        m_state = 1; m_busy = 0;
                    end
                end
                1: if (div_rdy_i) begin
                    m_q = m_x / m_y; m_r = m_x % m_y; m_err = 1'b0; m_state = 2;
                end else if (m_busy == TMO - 1) begin
                    m_q = '0; m_r = '0; m_err = 1'b1; m_state = 2;
                end else begin
                    m_busy++;
                end
                default: if (rsp_ready_i) begin
                    rsp_count++;
                    id_rsp[m_id]++;
                    m_state = 0;
                end
            endcase
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
        #1;
    endtask

    task automatic set_op(input int k, input logic [W-1:0] x, input logic [W-1:0] y);
        req_x_i[k*W +: W] = x;
        req_y_i[k*W +: W] = y;
    endtask

    task automatic rand_op(input int k, input bit allow_zero);
        logic [W-1:0] x;
        logic [W-1:0] y;
        int sel;
        sel = $urandom_range(0, 7);
        x = {$urandom, $urandom};
        case (sel)
            0: y = allow_zero ? '0 : 64'd3;
            1: begin x = x >> 1; y = x + 64'd1; end
            2: y = 64'($urandom_range(1, 20));
            3: begin x = 64'($urandom_range(0, 1000)); y = 64'($urandom_range(1, 50)); end
            default: y = {$urandom, $urandom} >> $urandom_range(0, 63);
        endcase
        if (y == 0 && !allow_zero) y = 64'd1;
        set_op(k, x, y);
    endtask

    task automatic submit(input int k, input logic [W-1:0] x, input logic [W-1:0] y);
        bit done;
        done = 0;
        step();
        set_op(k, x, y);
        req_valid_i[k] = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            sample();
            if (hs[k]) done = 1;
        end
        if (!done) chk("accept_timeout", 0, 1);
        step();
        req_valid_i[k] = 1'b0;
    endtask

    task automatic wait_rsp(input int limit);
        bit seen;
        seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            sample();
            if (rsp_valid_o) seen = 1;
        end
        if (!seen) chk("rsp_timeout", 0, 1);
    endtask

    task automatic release_rsp();
        step();
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
    endtask

    initial begin
        int snap;
        bit seen;
        reset = 1'b0;
        req_valid_i = '0;
        req_x_i = '0;
        req_y_i = '0;
        rsp_ready_i = 1'b0;
        repeat (2) step();
        req_valid_i = '1;
        sample();
        chk("reset_req_ready", W'(req_ready_o), '0);
        chk("reset_div_start", W'(div_start_o), '0);
        chk("reset_rsp_valid", W'(rsp_valid_o), '0);
        chk("reset_rsp_q", rsp_q_o, '0);
        step();
        req_valid_i = '0;
        reset = 1'b1;

        stub_fixed = 3;
        submit(1, 64'd100, 64'd7);
        wait_rsp(20);
        chk("t041_id", W'(rsp_id_o), 64'd1);
        chk("t041_q", rsp_q_o, 64'd14);
        chk("t041_r", rsp_r_o, 64'd2);
        chk("t041_err", W'(rsp_err_o), 64'd0);
        chk("t041_start_len", W'(last_run), 64'd4);
        release_rsp();

        stub_fixed = 0;
        submit(2, 64'd5, 64'd9);
        wait_rsp(20);
        chk("t042_q", rsp_q_o, 64'd0);
        chk("t042_r", rsp_r_o, 64'd5);
        chk("t042_start_len", W'(last_run), 64'd1);
        release_rsp();

        snap = start_rises;
        submit(0, 64'd123, 64'd0);
        wait_rsp(20);
        chk("t043_err", W'(rsp_err_o), 64'd1);
        chk("t043_q", rsp_q_o, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t043_r", rsp_r_o, 64'd123);
        step();
        for (int k = 1; k < NREQ; k++) set_op(k, 64'd50, 64'd3);
        req_valid_i = 4'b1110;
        for (int i = 0; i < 10; i++) begin
            sample();
            chk("t045_valid", W'(rsp_valid_o), 64'd1);
            chk("t045_q", rsp_q_o, 64'hFFFF_FFFF_FFFF_FFFF);
            chk("t045_r", rsp_r_o, 64'd123);
            chk("t045_id", W'(rsp_id_o), 64'd0);
            chk("t045_no_grant", W'(req_ready_o), 64'd0);
        end
        step();
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        req_valid_i = '0;
        sample();
        chk("t045_idle_next", W'(rsp_valid_o), 64'd0);
        chk("t043_no_start", W'(start_rises), W'(snap));

        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        grant_log.delete();
        have_prev = 0;
        min_gap = 1000;
        snap = rsp_count;
        stub_rand = 1;
        rsp_ready_i = 1'b1;
        for (int k = 0; k < NREQ; k++) rand_op(k, 0);
        req_valid_i = '1;
        for (int i = 0; i < 400 && req_valid_i != 0; i++) begin
            step();
            for (int k = 0; k < NREQ; k++) if (hs[k]) rand_op(k, 0);
            if (grant_log.size() >= 5) req_valid_i = '0;
        end
        for (int i = 0; i < 40 && rsp_count < snap + 5; i++) step();
        chk("t044_rsp_count", W'(rsp_count - snap), 64'd5);
        chk("t044_grants", W'(grant_log.size()), 64'd5);
        if (grant_log.size() >= 5) begin
            chk("t044_g0", W'(grant_log[0]), 64'd0);
            chk("t044_g1", W'(grant_log[1]), 64'd1);
            chk("t044_g2", W'(grant_log[2]), 64'd2);
            chk("t044_g3", W'(grant_log[3]), 64'd3);
            chk("t044_g4", W'(grant_log[4]), 64'd0);
        end
        chk("t044_gap_ge2", W'(min_gap >= 2), 64'd1);

        for (int i = 0; i < 800; i++) begin
            step();
            for (int k = 0; k < NREQ; k++) begin
                if (hs[k]) begin
                    rand_op(k, 1);
                    req_valid_i[k] = 1'($urandom_range(0, 1));
                end else if (!req_valid_i[k] && $urandom_range(0, 3) == 0) begin
                    rand_op(k, 1);
                    req_valid_i[k] = 1'b1;
                end
            end
            rsp_ready_i = ($urandom_range(0, 2) != 0);
            stub_stray = ($urandom_range(0, 4) == 0);
            reset = ($urandom_range(0, 199) != 0);
        end
        step();
        req_valid_i = '0;
        rsp_ready_i = 1'b1;
        stub_stray = 0;
        reset = 1'b1;
        repeat (20) step();
        rsp_ready_i = 1'b0;

        stub_rand = 0;
        stub_never = 1;
        submit(3, 64'd1000, 64'd5);
        wait_rsp(TMO + 20);
        chk("t046_err", W'(rsp_err_o), 64'd1);
        chk("t046_q", rsp_q_o, 64'd0);
        chk("t046_r", rsp_r_o, 64'd0);
        chk("t046_busy_len", W'(last_run), W'(TMO));
        release_rsp();
        submit(0, 64'd77, 64'd7);
        step();
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        sample();
        chk("t046_start_drop", W'(div_start_o), 64'd0);
        seen = 0;
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 30; i++) begin
            sample();
            if (rsp_valid_o) seen = 1;
        end
        chk("t046_no_rsp", W'(seen), 64'd0);
        stub_never = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
